// File: rtl/pc_sequencer_if.sv
// Run-control bus between the CPU top and the program-counter sequencer.
// The master drives run/step/decode/breakpoint controls; the slave returns pc, issue and status.
interface pc_sequencer_if #(
  parameter int unsigned PC_W  = 8,
  parameter int unsigned CNT_W = 16
);
  logic             run;
  logic             step;
  logic             stall;
  logic             halt_req;
  logic             jump_valid;
  logic [PC_W-1:0]  jump_addr;
  logic             bp_en;
  logic [PC_W-1:0]  bp_addr;
  logic [PC_W-1:0]  pc;
  logic             issue;
  logic [1:0]       state;
  logic             halted;
  logic [CNT_W-1:0] retired;

  modport master (
    output run, step, stall, halt_req, jump_valid, jump_addr, bp_en, bp_addr,
    input  pc, issue, state, halted, retired
  );

  modport slave (
    input  run, step, stall, halt_req, jump_valid, jump_addr, bp_en, bp_addr,
    output pc, issue, state, halted, retired
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program counter and run control: run/step/halt modes, PC breakpoint, fetch stall,
// and a saturating retired-instruction counter. issue gates datapath writes.
module pc_sequencer #(
  parameter int unsigned PC_W     = 8,
  parameter int unsigned RESET_PC = 0,
  parameter int unsigned CNT_W    = 16
) (
  input logic            clk,
  input logic            rst,
  pc_sequencer_if.slave  bus
);

  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_RUN    = 2'b01;
  localparam logic [1:0] ST_HALTED = 2'b10;
  localparam logic [1:0] ST_BREAK  = 2'b11;

  logic [1:0]       state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d, next_pc;
  logic [CNT_W-1:0] ret_q, ret_d;
  logic             step_q;
  logic             step_pend_q, step_pend_d;
  logic             halted_q;
  logic             step_rise;
  logic             step_mode;
  logic             issue_c;

  // Issue decision and the PC/counter/step bookkeeping that follows from it
  always_comb begin : datapath
    step_rise   = 1'b0;
    step_mode   = 1'b0;
    issue_c     = 1'b0;
    next_pc     = pc_q;
    pc_d        = pc_q;
    ret_d       = ret_q;
    step_pend_d = step_pend_q;

    step_rise = bus.step & ~step_q;
    step_mode = (state_q == ST_IDLE) || (state_q == ST_BREAK);
    issue_c   = ~bus.stall &
                ((state_q == ST_RUN) || (step_mode && (step_pend_q || step_rise)));

    if (bus.halt_req)        next_pc = pc_q;
    else if (bus.jump_valid) next_pc = bus.jump_addr;
    else                     next_pc = pc_q + PC_W'(1);

    if (issue_c) begin
      pc_d  = next_pc;
      ret_d = (ret_q == {CNT_W{1'b1}}) ? ret_q : ret_q + CNT_W'(1);
    end

    // A pending step survives stalls and is only meaningful in IDLE/BREAK
    if (!step_mode || issue_c) step_pend_d = 1'b0;
    else if (step_rise)        step_pend_d = 1'b1;
  end

  always_comb begin : next_state
    state_d = state_q;
    if (issue_c && bus.halt_req) begin
      state_d = ST_HALTED;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.run) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (!bus.run)
            state_d = ST_IDLE;
          else if (issue_c && bus.bp_en && (next_pc == bus.bp_addr))
            state_d = ST_BREAK;
        end
        ST_BREAK: begin
          if (!bus.run || issue_c) state_d = ST_IDLE;
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin : regs
    if (rst) begin
      state_q     <= ST_IDLE;
      pc_q        <= PC_W'(RESET_PC);
      ret_q       <= '0;
      step_q      <= 1'b0;
      step_pend_q <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ret_q       <= ret_d;
      step_q      <= bus.step;
      step_pend_q <= step_pend_d;
      halted_q    <= (state_d == ST_HALTED);
    end
  end

  assign bus.pc      = pc_q;
  assign bus.issue   = issue_c;
  assign bus.state   = state_q;
  assign bus.halted  = halted_q;
  assign bus.retired = ret_q;

endmodule
